// File: rtl/mul_seq.sv
// mul_seq: multi-cycle 16x16 shift-add multiply sequencer for the execute
// stage. Borrows the stage's shared 16-bit adder while a multiply is in
// flight and stalls the pipeline until the 32-bit product is ready.
//
// Optional feature macro: MUL_SIGNED_EN
//   defined   -> two's-complement operands supported (ABS/NEG states present)
//   undefined -> unsigned only; `sign` is ignored, every multiply takes 17 cycles
//
// Handshake: `start` is a request that is only accepted when the sequencer is
// IDLE and `flush` is low; `stall` rises combinationally in the accepting
// cycle and stays high until the cycle `done` pulses with the held product.
module mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        sign,
  input  logic        flush,
  input  logic [15:0] add_s,
  input  logic        add_cout,
  output logic        alu_own,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  output logic        stall,
  output logic        done,
  output logic [15:0] prod_lo,
  output logic [15:0] prod_hi
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_ITER   = 3'd3,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      state_q;
  logic [15:0] m_q;
  logic [15:0] p_hi_q;
  logic [15:0] p_lo_q;
  logic [3:0]  cnt_q;
`ifdef MUL_SIGNED_EN
  logic        neg_q;
  logic        c_q;
`else
  logic        unused_sign;
  assign unused_sign = sign;
`endif

  // Partial product after one shift-add step: adder result on top, shifted
  // multiplier bits below.
  logic [31:0] iter_p;
  assign iter_p = {add_cout, add_s, p_lo_q[15:1]};

  // Ownership and status are pure decodes of the state register; the start
  // term of stall is combinational so the MUL is held in EX when accepted.
  assign alu_own = (state_q != S_IDLE) && (state_q != S_DONE);
  assign stall   = alu_own || (start && (state_q == S_IDLE));
  assign done    = (state_q == S_DONE);

  // Steer the shared adder inputs; all zero when the adder is not owned.
  always_comb begin
    add_a   = 16'h0000;
    add_b   = 16'h0000;
    add_cin = 1'b0;
    case (state_q)
`ifdef MUL_SIGNED_EN
      S_ABS_A: begin
        add_a   = ~m_q;
        add_cin = 1'b1;
      end
      S_ABS_B: begin
        add_a   = ~p_lo_q;
        add_cin = 1'b1;
      end
      S_NEG_LO: begin
        add_a   = ~p_lo_q;
        add_cin = 1'b1;
      end
      S_NEG_HI: begin
        add_a   = ~p_hi_q;
        add_cin = c_q;
      end
`endif
      S_ITER: begin
        add_a = p_hi_q;
        add_b = p_lo_q[0] ? m_q : 16'h0000;
      end
      default: ;
    endcase
  end

  // Sequencer FSM: datapath registers, state and the held product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= 16'h0000;
      p_hi_q  <= 16'h0000;
      p_lo_q  <= 16'h0000;
      cnt_q   <= 4'd0;
      prod_hi <= 16'h0000;
      prod_lo <= 16'h0000;
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
      c_q     <= 1'b0;
`endif
    end else if (flush && (state_q != S_IDLE)) begin
      // Abort: product registers keep the previous result.
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            m_q    <= op_a;
            p_lo_q <= op_b;
            p_hi_q <= 16'h0000;
            cnt_q  <= 4'd0;
`ifdef MUL_SIGNED_EN
            neg_q   <= sign & (op_a[15] ^ op_b[15]);
            state_q <= sign ? S_ABS_A : S_ITER;
`else
            state_q <= S_ITER;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        S_ABS_A: begin
          if (m_q[15]) m_q <= add_s;
          state_q <= S_ABS_B;
        end
        S_ABS_B: begin
          if (p_lo_q[15]) p_lo_q <= add_s;
          state_q <= S_ITER;
        end
`endif
        S_ITER: begin
          {p_hi_q, p_lo_q} <= iter_p;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
`ifdef MUL_SIGNED_EN
            if (neg_q) begin
              state_q <= S_NEG_LO;
            end else begin
              state_q <= S_DONE;
              {prod_hi, prod_lo} <= iter_p;
            end
`else
            state_q <= S_DONE;
            {prod_hi, prod_lo} <= iter_p;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        S_NEG_LO: begin
          p_lo_q  <= add_s;
          c_q     <= add_cout;
          state_q <= S_NEG_HI;
        end
        S_NEG_HI: begin
          p_hi_q  <= add_s;
          prod_hi <= add_s;
          prod_lo <= p_lo_q;
          state_q <= S_DONE;
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed test of mul_seq with a cycle-level behavioural model
// (product from plain arithmetic, latency from the operand signs) checked on
// every cycle, plus hand-computed product/latency literals per vector.
// The shared adder is modelled here as a plain 16-bit adder.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, sign, flush;
  logic [15:0] op_a, op_b;
  logic [15:0] add_s;
  logic        add_cout;
  logic        alu_own;
  logic [15:0] add_a, add_b;
  logic        add_cin;
  logic        stall, done;
  logic [15:0] prod_lo, prod_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .sign(sign), .flush(flush), .add_s(add_s), .add_cout(add_cout),
    .alu_own(alu_own), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .stall(stall), .done(done), .prod_lo(prod_lo), .prod_hi(prod_hi)
  );

  // Clock / shared adder environment
  always #5 clk = ~clk;
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected product and latency from the operand values.
  function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic signed [31:0] sp;
`ifdef MUL_SIGNED_EN
    if (s) begin
      sp = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
      return sp;
    end
`endif
    sp = '0;
    return ({16'h0000, a} * {16'h0000, b}) + sp;
  endfunction

  function automatic int model_lat(input logic [15:0] a, input logic [15:0] b, input logic s);
`ifdef MUL_SIGNED_EN
    if (s) return (a[15] ^ b[15]) ? 21 : 19;
`endif
    if (a[15] && b[15] && s) return 17;
    return 17;
  endfunction

  // Model state: k = cycle index within the operation (0 = idle)
  int          k      = 0;
  int          lat_m  = 17;
  logic [31:0] exp_m  = '0;
  logic [31:0] prod_m = '0;
  bit          armed  = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0; prod_m = '0; armed = 1;
    end else if (k == 0) begin
      if (start && !flush) begin
        k = 1;
        lat_m = model_lat(op_a, op_b, sign);
        exp_m = model_prod(op_a, op_b, sign);
      end
    end else if (k == lat_m || flush) begin
      k = 0;
    end else begin
      k = k + 1;
      if (k == lat_m) prod_m = exp_m;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      logic own_e, done_e, stall_e;
      own_e   = (k != 0) && (k < lat_m);
      done_e  = (k != 0) && (k == lat_m);
      stall_e = own_e || ((k == 0) && start);
      check("cyc_alu_own", {31'b0, alu_own}, {31'b0, own_e});
      check("cyc_done",    {31'b0, done},    {31'b0, done_e});
      check("cyc_stall",   {31'b0, stall},   {31'b0, stall_e});
      check("cyc_prod",    {prod_hi, prod_lo}, prod_m);
      if (!own_e)
        check("cyc_adder_idle", {15'b0, add_cin, add_a}, 32'h0);
      if (!own_e)
        check("cyc_adder_b_idle", {16'b0, add_b}, 32'h0);
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    op_a = a; op_b = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp, input int lat, output int own);
    own = 0;
    while (!done && cyc <= 40) begin
      if (alu_own) own++;
      step(1);
    end
    check({name, "_done"}, {31'b0, done}, 32'd1);
    check({name, "_lat"}, cyc, lat);
    check({name, "_prod"}, {prod_hi, prod_lo}, exp);
    step(1);
  endtask

  int own;

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; sign = 1'b0;
    op_a = '0; op_b = '0;
    step(3);
    check("reset_prod",  {prod_hi, prod_lo}, 32'h0);
    check("reset_flags", {29'b0, stall, done, alu_own}, 32'h0);
    rst_n = 1'b1;
    step(2);

    start_op(16'h00FF, 16'h0101, 1'b0);
    wait_done("u_ff_101", 32'h0000_FFFF, 17, own);
    step(1);

    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done("u_ffff_sq", 32'hFFFE_0001, 17, own);
    check("u_ffff_own_cycles", own, 16);
    step(1);

`ifdef MUL_SIGNED_EN
    start_op(16'hFFFD, 16'h0005, 1'b1);
    wait_done("s_m3x5", 32'hFFFF_FFF1, 21, own);
    check("s_m3x5_own_cycles", own, 20);
    start_op(16'h8000, 16'h8000, 1'b1);
    wait_done("s_8000_sq", 32'h4000_0000, 19, own);
    start_op(16'h0007, 16'hFFFE, 1'b1);
    wait_done("s_7xm2", 32'hFFFF_FFF2, 21, own);
    start_op(16'd100, 16'd200, 1'b1);
    wait_done("s_100x200", 32'h0000_4E20, 19, own);
`else
    start_op(16'hFFFD, 16'h0005, 1'b1);
    wait_done("s_m3x5", 32'h0004_FFF1, 17, own);
    start_op(16'h8000, 16'h8000, 1'b1);
    wait_done("s_8000_sq", 32'h4000_0000, 17, own);
    start_op(16'h0007, 16'hFFFE, 1'b1);
    wait_done("s_7xm2", 32'h0006_FFF2, 17, own);
    start_op(16'd100, 16'd200, 1'b1);
    wait_done("s_100x200", 32'h0000_4E20, 17, own);
`endif
    step(1);

    // Flush in the 5th ITER cycle (T+5)
    start_op(16'h1234, 16'h5678, 1'b0);
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("flush_stall", {31'b0, stall}, 32'h0);
    check("flush_done",  {31'b0, done},  32'h0);
    check("flush_prod_kept", {prod_hi, prod_lo}, 32'h0000_4E20);
    step(20);
    start_op(16'd2, 16'd3, 1'b0);
    wait_done("after_flush_2x3", 32'h0000_0006, 17, own);
    step(1);

    // start pulsed mid-operation with other operands is ignored
    start_op(16'd3, 16'd7, 1'b0);
    step(3);
    op_a = 16'h00FF; op_b = 16'h00FF; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done("ignored_start_3x7", 32'h0000_0015, 17, own);
    step(1);

    // Reset during ITER
    start_op(16'h0123, 16'h0456, 1'b0);
    step(5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("midrst_prod",  {prod_hi, prod_lo}, 32'h0);
    check("midrst_flags", {29'b0, stall, done, alu_own}, 32'h0);
    step(1);
    start_op(16'h0010, 16'h0010, 1'b0);
    wait_done("after_rst_16x16", 32'h0000_0100, 17, own);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle 16×16 multiply sequencer for the execute stage. When a MUL-class instruction reaches execute, it takes over the stage's shared 16-bit adder for the duration of the operation, steering the adder inputs itself. It freezes the pipeline with `stall` until the 32-bit product is ready, then hands the adder back and pulses `done` with the result.

## Interface
- No parameters.
- `clk`  in  1  stage clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  begin a multiply this cycle; accepted only in IDLE.
- `op_a`, `op_b`  in  16  multiplicand and multiplier; sampled on accepted `start`.
- `sign`  in  1  1 = two's-complement operands; sampled with operands.
- `flush`  in  1  abort any operation in progress.
- `add_s`  in  16  shared adder sum.
- `add_cout`  in  1  shared adder carry-out.
- `alu_own`  out  1  1 = the execute-stage adder input mux selects `add_a`/`add_b`/`add_cin`.
- `add_a`, `add_b`  out  16  adder operands.
- `add_cin`  out  1  adder carry-in.
- `stall`  out  1  freeze IF/ID/EX registers.
- `done`  out  1  one-cycle pulse; product valid.
- `prod_lo`, `prod_hi`  out  16  product; held until the next accepted `start`.

## Operation
- Registers:
  - `M` (16): magnitude of A.
  - `P_hi`, `P_lo` (16 each): partial product.
  - `cnt` (4).
  - `neg` (1): result sign.
  - `c` (1): saved carry.
- States: IDLE, ABS_A, ABS_B, ITER, NEG_LO, NEG_HI, DONE.
- **IDLE**
  - On `start`: load `M`=op_a, `P_lo`=op_b, `P_hi`=0, `cnt`=0, `neg`=sign&(op_a[15]^op_b[15]).
  - Next state is ABS_A if `sign`, else ITER.
- **ABS_A**
  - Adder inputs: `add_a`=~M, `add_b`=0, `add_cin`=1.
  - If `M[15]`, `M`<=add_s. Next state ABS_B.
- **ABS_B**
  - Same operation applied to `P_lo`. Next state ITER.
- Magnitudes are unsigned 16-bit, so 0x8000 remains 0x8000.
- **ITER**
  - Adder inputs: `add_a`=P_hi, `add_b`=P_lo[0]?M:0, `add_cin`=0.
  - Update: {P_hi,P_lo} <= {add_cout, add_s, P_lo[15:1]}; `cnt`++.
  - After the 16th iteration (cnt==15): go to NEG_LO if `neg`, else DONE.
- **NEG_LO**
  - Adder inputs: `add_a`=~P_lo, `add_b`=0, `add_cin`=1.
  - `P_lo`<=add_s; `c`<=add_cout.
- **NEG_HI**
  - Adder inputs: `add_a`=~P_hi, `add_b`=0, `add_cin`=c.
  - `P_hi`<=add_s. Next state DONE.
- **DONE**
  - `done`=1; `prod_hi`/`prod_lo` <= P_hi/P_lo on entry to DONE.
  - Next state IDLE.
- `alu_own`=1 in ABS_A, ABS_B, ITER, NEG_LO and NEG_HI; 0 in IDLE and DONE.
  - `add_a`/`add_b`/`add_cin` = 0 whenever `alu_own`=0.
- `stall` = (state ∉ {IDLE, DONE}) | (start & state==IDLE).
  - The start term is combinational so that the MUL instruction is held in EX in the same cycle it is accepted.
- `start` outside IDLE is ignored, with no side effects.
- **flush**
  - In any non-IDLE state: next state IDLE, no `done`, `prod_*` unchanged.
  - Flush has priority over `start` in the same cycle; `start` is dropped.
- **Reset** (`rst_n`=0 at an edge), including mid-operation:
  - state IDLE.
  - All registers and `prod_*` = 0.
  - `done`=`stall`=`alu_own`=0.

## Timing
- Latency, counting `start` accepted at edge T (the same cycle as `stall` first rises):
  - Unsigned: ITER occupies cycles T+1..T+16; DONE (`done`=1, `stall`=0) at cycle T+17.
  - Signed: ABS T+1..T+2, ITER T+3..T+18, NEG T+19..T+20 only when `neg`=1, DONE T+19 or T+21.
- Throughput: the next `start` is accepted in the IDLE cycle after DONE, at the earliest.
- `done` is never asserted for two consecutive cycles.
- No path from `add_s`/`add_cout` to any output; they are registered only.

## Configuration
- `MUL_SIGNED_EN` defined:
  - Signed support as above.
- `MUL_SIGNED_EN` undefined:
  - `sign` is ignored and `neg` is forced to 0.
  - ABS_A, ABS_B, NEG_LO and NEG_HI are compiled out; IDLE goes straight to ITER.
  - Every multiply completes at T+17.

## Test plan
- Unsigned 0x00FF×0x0101 → {prod_hi,prod_lo}=0x0000_FFFF; `done` at T+17; `stall` high for T..T+16 only.
- Unsigned 0xFFFF×0xFFFF → 0xFFFE_0001. `alu_own` high exactly 16 cycles.
- Signed: −3(0xFFFD)×5 → 0xFFFF_FFF1, `done` at T+21; 0x8000×0x8000 → 0x4000_0000, `done` at T+19.
- `flush` in the 5th ITER cycle → no `done`, `stall`=0 the next cycle, `prod_*` keep old value; then 2×3 → 0x0000_0006.
- `start` pulsed during ITER with different operands → ignored; the original product is returned.
- `rst_n`=0 during ITER → all outputs 0 the next cycle, state IDLE; the next `start` multiplies correctly.
